// File: rtl/dpram_sync.sv
// dpram_sync: true dual-port synchronous RAM with byte enables, cross-port
// read-during-write selection (RDW_MODE), out-of-range flagging and
// optional output register enabled by the DPRAM_OUTREG_EN macro.
// The memory array is never reset; only the read pipelines are.

// Per-port read return pipeline: q/valid/err with STAGES cycles of latency.
module dpram_sync_port #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,       // read accepted this edge
    input  logic              oor,      // out-of-range access accepted this edge
    input  logic [DATA_W-1:0] rd_word,  // word to return (already zeroed if oor)
    output logic [DATA_W-1:0] q,
    output logic              valid,
    output logic              err
);
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1]             err_pipe;
    logic [STAGES:1][DATA_W-1:0] q_pipe;

    // Shift valid/err every cycle; data stages only load behind a valid read so q holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            q_pipe   <= '0;
        end else begin
            vld_pipe[1] <= rd;
            err_pipe[1] <= oor;
            if (rd) q_pipe[1] <= rd_word;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                err_pipe[s] <= err_pipe[s-1];
                if (vld_pipe[s-1]) q_pipe[s] <= q_pipe[s-1];
            end
        end
    end

    assign q     = q_pipe[STAGES];
    assign valid = vld_pipe[STAGES];
    assign err   = err_pipe[STAGES];
endmodule

module dpram_sync #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_a,
    input  logic                req_b,
    input  logic                we_a,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   address_a,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [DATA_W-1:0]   data_a,
    input  logic [DATA_W-1:0]   data_b,
    output logic [DATA_W-1:0]   q_a,
    output logic [DATA_W-1:0]   q_b,
    output logic                valid_a,
    output logic                valid_b,
    output logic                err_a,
    output logic                err_b
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef DPRAM_OUTREG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    // Index 0 is port A, index 1 is port B
    logic [1:0]              req, we, in_rng, wr;
    logic [1:0][NB-1:0]      be;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][IDX_W-1:0]   idx;
    logic [1:0][DATA_W-1:0]  din, merged, rd_word, q;
    logic [1:0]              valid, err;

    logic [DATA_W-1:0] mem [DEPTH];

    assign req  = {req_b, req_a};
    assign we   = {we_b, we_a};
    assign be   = {be_b, be_a};
    assign addr = {address_b, address_a};
    assign din  = {data_b, data_a};

    // Address decode: range check, array index, qualified write strobe
    always_comb begin
        in_rng = '0;
        idx    = '0;
        wr     = '0;
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = {1'b0, addr[p]} < DEPTH_L;
            idx[p]    = addr[p][IDX_W-1:0];
            wr[p]     = req[p] & we[p] & in_rng[p];
        end
    end

    // Post-write word of each port, and the word each port's read should return
    always_comb begin
        merged  = '0;
        rd_word = '0;
        for (int p = 0; p < 2; p++) begin
            merged[p] = mem[idx[p]];
            for (int b = 0; b < NB; b++)
                if (be[p][b]) merged[p][8*b +: 8] = din[p][8*b +: 8];
        end
        for (int p = 0; p < 2; p++) begin
            if (RDW_MODE == 1 && wr[1-p] && idx[1-p] == idx[p])
                rd_word[p] = merged[1-p];
            else
                rd_word[p] = mem[idx[p]];
            if (!in_rng[p]) rd_word[p] = '0;
        end
    end

    // Array update: B bytes first so A's bytes take precedence on a shared address
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (wr[1] && be[1][b]) mem[idx[1]][8*b +: 8] <= din[1][8*b +: 8];
        for (int b = 0; b < NB; b++)
            if (wr[0] && be[0][b]) mem[idx[0]][8*b +: 8] <= din[0][8*b +: 8];
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        dpram_sync_port #(.DATA_W(DATA_W), .STAGES(STAGES)) u_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd      (req[p] & ~we[p]),
            .oor     (req[p] & ~in_rng[p]),
            .rd_word (rd_word[p]),
            .q       (q[p]),
            .valid   (valid[p]),
            .err     (err[p])
        );
    end

    assign q_a     = q[0];
    assign q_b     = q[1];
    assign valid_a = valid[0];
    assign valid_b = valid[1];
    assign err_a   = err[0];
    assign err_b   = err[1];
endmodule

// File: tb/tb_dpram_sync.sv
// Bench for dpram_sync: two instances (RDW_MODE 0 and 1) share one stimulus.
// A cycle-indexed result model predicts q/valid/err; literal checks pin it.
module tb_dpram_sync;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_a = 0, req_b = 0, we_a = 0, we_b = 0;
    logic [3:0]  be_a = 0, be_b = 0;
    logic [15:0] address_a = 0, address_b = 0;
    logic [31:0] data_a = 0, data_b = 0;
    logic [31:0] q_a [2];
    logic [31:0] q_b [2];
    logic        valid_a [2], valid_b [2], err_a [2], err_b [2];

    for (genvar m = 0; m < 2; m++) begin : g_dut
        dpram_sync #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .RDW_MODE(m)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
            .be_a(be_a), .be_b(be_b), .address_a(address_a), .address_b(address_b),
            .data_a(data_a), .data_b(data_b),
            .q_a(q_a[m]), .q_b(q_b[m]), .valid_a(valid_a[m]), .valid_b(valid_b[m]),
            .err_a(err_a[m]), .err_b(err_b[m])
        );
    end

    int n_chk = 0;
    int n_fail = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { bit v; bit e; logic [31:0] q0; logic [31:0] q1; } res_t;
    res_t        ev [2][4096];         // result of each port's access, by accept cycle
    logic [31:0] mm [int];             // memory contents
    int          cyc = 0;              // accepting edges since start
    int          last_rst = 0;         // accepts at or before this cycle are discarded
    bit          exp_v [2], exp_e [2];
    logic [31:0] exp_q [2][2];         // [mode][port]

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_step();
        bit rq [2], w [2];
        logic [3:0] bb [2];
        int ad [2];
        logic [31:0] dd [2], old;
        res_t r;
        int i;
        if (!rst_n) begin
            last_rst = cyc;
            for (int p = 0; p < 2; p++) begin
                exp_v[p] = 0; exp_e[p] = 0; exp_q[0][p] = '0; exp_q[1][p] = '0;
            end
            return;
        end
        cyc++;
        rq[0] = req_a; w[0] = we_a; bb[0] = be_a; ad[0] = int'(address_a); dd[0] = data_a;
        rq[1] = req_b; w[1] = we_b; bb[1] = be_b; ad[1] = int'(address_b); dd[1] = data_b;
        for (int p = 0; p < 2; p++) begin
            r = '{v: rq[p] && !w[p], e: rq[p] && ad[p] >= DEPTH, q0: '0, q1: '0};
            if (r.v && ad[p] < DEPTH) begin
                old  = mm.exists(ad[p]) ? mm[ad[p]] : 'x;
                r.q0 = old;
                r.q1 = (rq[1-p] && w[1-p] && ad[1-p] == ad[p]) ? merge(old, dd[1-p], bb[1-p]) : old;
            end
            if (cyc < 4096) ev[p][cyc] = r;
        end
        for (int p = 1; p >= 0; p--)  // port A applied last: it wins shared bytes
            if (rq[p] && w[p] && ad[p] < DEPTH)
                mm[ad[p]] = merge(mm.exists(ad[p]) ? mm[ad[p]] : 'x, dd[p], bb[p]);
        i = cyc - LAT + 1;
        for (int p = 0; p < 2; p++) begin
            if (i > last_rst && i >= 1 && i < 4096) begin
                exp_v[p] = ev[p][i].v;
                exp_e[p] = ev[p][i].e;
                if (ev[p][i].v) begin exp_q[0][p] = ev[p][i].q0; exp_q[1][p] = ev[p][i].q1; end
            end else begin
                exp_v[p] = 0; exp_e[p] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // Compare every DUT output against the model on every falling edge
    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("dut%0d q_a", m),     q_a[m],     exp_q[m][0]);
                chk($sformatf("dut%0d q_b", m),     q_b[m],     exp_q[m][1]);
                chk($sformatf("dut%0d valid_a", m), 32'(valid_a[m]), 32'(exp_v[0]));
                chk($sformatf("dut%0d valid_b", m), 32'(valid_b[m]), 32'(exp_v[1]));
                chk($sformatf("dut%0d err_a", m),   32'(err_a[m]),   32'(exp_e[0]));
                chk($sformatf("dut%0d err_b", m),   32'(err_b[m]),   32'(exp_e[1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        req_a = 0; req_b = 0; we_a = 0; we_b = 0; be_a = 0; be_b = 0;
    endtask

    task automatic drv(input int p, input bit we, input logic [3:0] be,
                       input int addr, input logic [31:0] d);
        if (p == 0) begin
            req_a = 1; we_a = we; be_a = be; address_a = 16'(addr); data_a = d;
        end else begin
            req_b = 1; we_b = we; be_b = be; address_b = 16'(addr); data_b = d;
        end
    endtask

    task automatic settle();  // inputs off, wait until results of the last accept are visible
        step(); idle();
        repeat (LAT - 1) step();
    endtask

    initial begin
        idle();
        step();
        started = 1;
        step(); step();
        for (int m = 0; m < 2; m++) begin
            chk("reset q_a", q_a[m], 32'h0);
            chk("reset valid_a/err_a", {31'b0, valid_a[m] | err_a[m]}, 32'h0);
        end
        rst_n = 1;

        // write then read back on port A
        drv(0, 1, 4'hF, 0, 32'hDEADBEEF); step(); idle();
        drv(0, 0, 4'h0, 0, 32'h0); settle();
        chk("rd0 q_a", q_a[0], 32'hDEADBEEF);
        chk("rd0 valid_a", 32'(valid_a[0]), 32'h1);
        step();
        chk("rd0 hold q_a", q_a[0], 32'hDEADBEEF);
        chk("rd0 pulse valid_a", 32'(valid_a[0]), 32'h0);

        // byte-enabled write from B
        drv(0, 1, 4'hF, 5, 32'h11223344); step(); idle();
        drv(1, 1, 4'b0101, 5, 32'hAABBCCDD); step(); idle();
        drv(1, 0, 4'h0, 5, 32'h0); settle();
        chk("be q_b", q_b[0], 32'h11BB33DD);

        // cross-port read-during-write, both directions
        drv(0, 1, 4'hF, 3, 32'h0); step(); idle();
        drv(0, 1, 4'hF, 3, 32'h12345678); drv(1, 0, 4'h0, 3, 32'h0); settle();
        chk("rdw old q_b", q_b[0], 32'h00000000);
        chk("rdw new q_b", q_b[1], 32'h12345678);
        drv(1, 1, 4'b0011, 3, 32'hCAFEBABE); drv(0, 0, 4'h0, 3, 32'h0); settle();
        chk("rdw old q_a", q_a[0], 32'h12345678);
        chk("rdw new q_a", q_a[1], 32'h1234BABE);

        // same-address write collisions
        drv(0, 1, 4'hF, 7, 32'hAAAAAAAA); drv(1, 1, 4'hF, 7, 32'h55555555); step(); idle();
        drv(0, 0, 4'h0, 7, 32'h0); settle();
        chk("wcol full q_a", q_a[0], 32'hAAAAAAAA);
        drv(0, 1, 4'b0011, 8, 32'hAAAAAAAA); drv(1, 1, 4'b1110, 8, 32'h55555555); step(); idle();
        drv(1, 0, 4'h0, 8, 32'h0); drv(0, 0, 4'h0, 7, 32'h0); settle();
        chk("wcol part q_b", q_b[0], 32'h5555AAAA);

        // range boundary
        drv(0, 1, 4'hF, 976, 32'h13579BDF); drv(1, 1, 4'hF, DEPTH - 1, 32'h0BADF00D); step(); idle();
        drv(0, 0, 4'h0, DEPTH, 32'h0); settle();
        chk("oor q_a", q_a[0], 32'h0);
        chk("oor valid_a", 32'(valid_a[0]), 32'h1);
        chk("oor err_a", 32'(err_a[0]), 32'h1);
        step();
        chk("oor err_a pulse", 32'(err_a[0]), 32'h0);
        drv(1, 1, 4'hF, 2000, 32'hFFFFFFFF); settle();
        chk("oor wr err_b", 32'(err_b[1]), 32'h1);
        chk("oor wr valid_b", 32'(valid_b[1]), 32'h0);
        drv(0, 0, 4'h0, 976, 32'h0); drv(1, 0, 4'h0, DEPTH - 1, 32'h0); settle();
        chk("oor wr no alias q_a", q_a[0], 32'h13579BDF);
        chk("top addr q_b", q_b[1], 32'h0BADF00D);

        // reset with a read in flight
        drv(0, 0, 4'h0, 0, 32'h0); drv(1, 0, 4'h0, 5, 32'h0);
        @(posedge clk); #1 rst_n = 0; #1;
        chk("rst q_a", q_a[0], 32'h0);
        chk("rst valid_a", 32'(valid_a[0]), 32'h0);
        chk("rst q_b", q_b[1], 32'h0);
        step(); idle(); step(); step();
        rst_n = 1;
        repeat (3) step();
        chk("post rst valid_a", 32'(valid_a[0]), 32'h0);
        drv(0, 0, 4'h0, 0, 32'h0); drv(1, 0, 4'h0, 5, 32'h0); settle();
        chk("mem kept q_a", q_a[1], 32'hDEADBEEF);
        chk("mem kept q_b", q_b[0], 32'h11BB33DD);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
